muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 40 ++++
 rtl/md_timeout_cnt.sv | 33 +++
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared defines for the EX-stage multiply/divide control: datapath widths,
// operation codes, FSM encodings and small op-decoding helpers.
package muldiv_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int HILO_W = 2 * XLEN;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MUL   = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } md_state_e;

  function automatic logic op_is_mult(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // MUL writes a GPR through res_lo, never HI/LO.
  function automatic logic op_writes_hilo(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_timeout_cnt.sv
// Saturating RUN-cycle counter; hit fires on the increment that reaches TIMEOUT_CYC.
// Latency: hit is combinational from the registered count; no backpressure.
module md_timeout_cnt
  import muldiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = inc && (cnt_q >= LAST);

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for external MultCore/DivCore: start, wait, capture, commit HI/LO.
// Latency: one start cycle plus core latency; stalls EX until the result is available.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             hold,
  input  logic             op_valid,
  input  logic [2:0]       op_sel,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  output logic             mult_start,
  output logic             mult_sign,
  output logic [XLEN-1:0]  mult_a,
  output logic [XLEN-1:0]  mult_b,
  input  logic             mult_ready,
  input  logic             mult_busy,
  input  logic [HILO_W-1:0] mult_result,
  output logic             div_start,
  output logic             div_sign,
  output logic [XLEN-1:0]  div_a,
  output logic [XLEN-1:0]  div_b,
  input  logic             div_ready,
  input  logic             div_busy,
  input  logic [HILO_W-1:0] div_result,
  output logic             stallreq,
  output logic             res_valid,
  output logic [XLEN-1:0]  res_hi,
  output logic [XLEN-1:0]  res_lo,
  output logic             hilo_we,
  output logic             md_err
);

  md_state_e       state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            err_q;

  logic in_mult, in_div, in_legal, in_busy;
  logic q_mult, q_ready, q_busy;
  logic cnt_hit, start_go, capture, timeout_abort;
  logic stall, done_vld, we, illegal;

  assign in_mult  = op_is_mult(op_sel);
  assign in_div   = op_is_div(op_sel);
  assign in_legal = in_mult || in_div;
  assign in_busy  = in_mult ? mult_busy : div_busy;

  assign q_mult  = op_is_mult(op_q);
  assign q_ready = q_mult ? mult_ready : div_ready;
  assign q_busy  = q_mult ? mult_busy  : div_busy;

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    done_vld = 1'b0;
    we       = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = op_valid;
        if (op_valid && !flush) begin
          if (!in_legal) begin
            illegal = 1'b1;
            stall   = 1'b0;
          end else if (!in_busy) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (flush)        state_d = ST_ABORT;
        else if (q_ready) state_d = ST_DONE;
        else if (cnt_hit) state_d = ST_ABORT;
      end
      ST_DONE: begin
        done_vld = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          we      = op_writes_hilo(op_q);
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        // The core cannot be cancelled, so wait for it to drain.
        stall = op_valid;
        if (!q_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_go      = (state_q == ST_IDLE) && (state_d == ST_RUN);
  assign capture       = (state_q == ST_RUN) && !flush && q_ready;
  assign timeout_abort = (state_q == ST_RUN) && !flush && !q_ready && cnt_hit;

  md_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start_go),
    .inc    (state_q == ST_RUN),
    .hit    (cnt_hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) op_q <= op_sel;
      if (capture) begin
        if (q_mult) begin
          hi_q <= (op_q == OP_MUL) ? '0 : mult_result[HILO_W-1:XLEN];
          lo_q <= mult_result[XLEN-1:0];
        end else begin
          hi_q <= div_result[HILO_W-1:XLEN];
          lo_q <= div_result[XLEN-1:0];
        end
      end
      if (timeout_abort) err_q <= 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign mult_start = resetn && start_go && in_mult;
  assign mult_sign  = mult_start && op_signed(op_sel);
  assign mult_a     = mult_start ? src_a : '0;
  assign mult_b     = mult_start ? src_b : '0;
  assign div_start  = resetn && start_go && in_div;
  assign div_sign   = div_start && op_signed(op_sel);
  assign div_a      = div_start ? src_a : '0;
  assign div_b      = div_start ? src_b : '0;

  assign stallreq  = resetn && stall;
  assign res_valid = resetn && (done_vld || illegal);
  assign hilo_we   = resetn && we;
  assign res_hi    = illegal ? '0 : hi_q;
  assign res_lo    = illegal ? '0 : lo_q;
  assign md_err    = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural MultCore/DivCore models.
// Timeout shortened to 8 cycles so the abort path is reachable quickly.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush, hold, op_valid;
  logic [2:0]  op_sel;
  logic [31:0] src_a, src_b;
  logic        mult_start, mult_sign, div_start, div_sign;
  logic [31:0] mult_a, mult_b, div_a, div_b;
  logic        mult_ready, mult_busy, div_ready, div_busy;
  logic [63:0] mult_result, div_result;
  logic        stallreq, res_valid, hilo_we, md_err;
  logic [31:0] res_hi, res_lo;

  int n_pass = 0;
  int n_total = 0;
  int mult_lat = 4;
  int div_lat = 3;
  bit d_abandon = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .hold(hold),
    .op_valid(op_valid), .op_sel(op_sel), .src_a(src_a), .src_b(src_b),
    .mult_start(mult_start), .mult_sign(mult_sign), .mult_a(mult_a), .mult_b(mult_b),
    .mult_ready(mult_ready), .mult_busy(mult_busy), .mult_result(mult_result),
    .div_start(div_start), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_busy(div_busy), .div_result(div_result),
    .stallreq(stallreq), .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
    .hilo_we(hilo_we), .md_err(md_err)
  );

  // MultCore model: ready pulses mult_lat cycles after start (0 = never).
  initial begin
    logic go;
    logic [63:0] m_res;
    int cnt;
    mult_ready = 0; mult_busy = 0; mult_result = '0; cnt = 0; m_res = '0;
    forever begin
      @(negedge clk);
      go = mult_start;
      if (go) begin
        if (mult_sign) m_res = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
        else           m_res = {32'd0, mult_a} * {32'd0, mult_b};
      end
      @(posedge clk); #1;
      if (!resetn) begin mult_busy = 0; mult_ready = 0; end
      else if (go) begin mult_busy = 1; cnt = 1; mult_ready = (mult_lat == 1); mult_result = m_res; end
      else if (mult_ready) begin mult_busy = 0; mult_ready = 0; end
      else if (mult_busy) begin cnt++; mult_ready = (cnt == mult_lat); end
    end
  end

  // DivCore model: {remainder, quotient}; d_abandon drops a stuck busy.
  initial begin
    logic go;
    logic [63:0] d_res;
    int cnt;
    div_ready = 0; div_busy = 0; div_result = '0; cnt = 0; d_res = '0;
    forever begin
      @(negedge clk);
      go = div_start;
      if (go) begin
        if (div_b == 0)    d_res = {div_a, 32'hFFFF_FFFF};
        else if (div_sign) d_res = {32'($signed(div_a) % $signed(div_b)), 32'($signed(div_a) / $signed(div_b))};
        else               d_res = {div_a % div_b, div_a / div_b};
      end
      @(posedge clk); #1;
      if (!resetn) begin div_busy = 0; div_ready = 0; end
      else if (d_abandon) begin div_busy = 0; div_ready = 0; d_abandon = 0; end
      else if (go) begin div_busy = 1; cnt = 1; div_ready = (div_lat == 1); div_result = d_res; end
      else if (div_ready) begin div_busy = 0; div_ready = 0; end
      else if (div_busy) begin cnt++; div_ready = (cnt == div_lat); end
    end
  end

  // Presents one op until the result leaves DONE; hold_n stalls DONE that many cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n, output int n_stall, output int n_ms, output int n_ds,
                        output int n_we, output int n_valid, output logic [31:0] hi,
                        output logic [31:0] lo, output logic sgn, output bit done,
                        output bit stable, output bit leak);
    int  hold_left;
    bit  got, fin;
    op_valid = 1; op_sel = op; src_a = a; src_b = b; hold = 0; flush = 0;
    n_stall = 0; n_ms = 0; n_ds = 0; n_we = 0; n_valid = 0; hi = '0; lo = '0; sgn = 0;
    done = 0; stable = 1; leak = 0; hold_left = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stallreq) n_stall++;
      if (mult_start) begin n_ms++; sgn = mult_sign; end
      if (div_start)  begin n_ds++; sgn = div_sign; end
      if (hilo_we) n_we++;
      if ((!mult_start && (mult_a != 0 || mult_b != 0)) || (!div_start && (div_a != 0 || div_b != 0))) leak = 1;
      if (res_valid) begin
        n_valid++;
        if (got && ({hi, lo} !== {res_hi, res_lo})) stable = 0;
        hi = res_hi; lo = res_lo; got = 1;
      end
      fin = res_valid && !hold;
      if ((mult_ready || div_ready) && hold_n > 0) hold_left = hold_n;
      @(posedge clk); #1;
      if (fin) begin done = 1; break; end
      if (hold_left > 0) begin hold = 1; hold_left--; end else hold = 0;
    end
    op_valid = 0; hold = 0;
  endtask

  task automatic test_reset();
    resetn = 0; flush = 0; hold = 0; op_valid = 1; op_sel = OP_MULT; src_a = 32'h55; src_b = 32'hAA;
    @(negedge clk);
    n_total++; if ({mult_start, mult_sign, div_start, div_sign, stallreq, res_valid, hilo_we, md_err} !== 8'b0)
      $display("FAIL reset_ctrl: got %b want 00000000", {mult_start, mult_sign, div_start, div_sign, stallreq, res_valid, hilo_we, md_err}); else n_pass++;
    n_total++; if ({mult_a, mult_b, div_a, div_b} !== 128'b0)
      $display("FAIL reset_operands: got %h want 0", {mult_a, mult_b, div_a, div_b}); else n_pass++;
    n_total++; if ({res_hi, res_lo} !== 64'b0)
      $display("FAIL reset_result: got %h want 0", {res_hi, res_lo}); else n_pass++;
    op_valid = 0;
    @(posedge clk); #3;
    resetn = 1;
  endtask

  task automatic test_mult();
    int ns, nm, nd, nw, nv; logic [31:0] hi, lo; logic sg; bit dn, st, lk;
    mult_lat = 4;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, ns, nm, nd, nw, nv, hi, lo, sg, dn, st, lk);
    n_total++; if (!dn) $display("FAIL mult_done: no result within budget"); else n_pass++;
    n_total++; if (ns !== 5) $display("FAIL mult_stall_cycles: got %0d want 5", ns); else n_pass++;
    n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else n_pass++;
    n_total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h want fffffffa", lo); else n_pass++;
    n_total++; if (nw !== 1) $display("FAIL mult_hilo_we: got %0d want 1", nw); else n_pass++;
    n_total++; if (nm !== 1 || nd !== 0) $display("FAIL mult_starts: got mult %0d div %0d want 1/0", nm, nd); else n_pass++;
    n_total++; if (sg !== 1'b1) $display("FAIL mult_sign: got %b want 1", sg); else n_pass++;
    n_total++; if (lk) $display("FAIL mult_operand_zero: operands nonzero without start"); else n_pass++;
  endtask

  task automatic test_illegal();
    op_valid = 1; op_sel = 3'd7; src_a = 32'h1234; src_b = 32'h5678;
    @(negedge clk);
    n_total++; if ({res_valid, stallreq} !== 2'b10) $display("FAIL illegal_valid_stall: got %b want 10", {res_valid, stallreq}); else n_pass++;
    n_total++; if ({mult_start, div_start, hilo_we} !== 3'b0) $display("FAIL illegal_no_start: got %b want 000", {mult_start, div_start, hilo_we}); else n_pass++;
    n_total++; if ({res_hi, res_lo} !== 64'b0) $display("FAIL illegal_zero_result: got %h want 0", {res_hi, res_lo}); else n_pass++;
    @(posedge clk); #1;
    op_valid = 0;
    @(negedge clk);
    n_total++; if ({res_valid, stallreq} !== 2'b00) $display("FAIL illegal_one_cycle: got %b want 00", {res_valid, stallreq}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_hold();
    int ns, nm, nd, nw, nv; logic [31:0] hi, lo; logic sg; bit dn, st, lk;
    div_lat = 3;
    run_op(OP_DIVU, 32'd100, 32'd7, 3, ns, nm, nd, nw, nv, hi, lo, sg, dn, st, lk);
    n_total++; if (!dn) $display("FAIL divu_done: no result within budget"); else n_pass++;
    n_total++; if (lo !== 32'd14) $display("FAIL divu_quotient: got %0d want 14", lo); else n_pass++;
    n_total++; if (hi !== 32'd2) $display("FAIL divu_remainder: got %0d want 2", hi); else n_pass++;
    n_total++; if (nw !== 1) $display("FAIL divu_hilo_we: got %0d want 1", nw); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL divu_single_start: got %0d want 1", nd); else n_pass++;
    n_total++; if (sg !== 1'b0) $display("FAIL divu_sign: got %b want 0", sg); else n_pass++;
    n_total++; if (nv !== 4) $display("FAIL divu_valid_cycles: got %0d want 4", nv); else n_pass++;
    n_total++; if (!st) $display("FAIL divu_result_held: result changed during hold"); else n_pass++;
  endtask

  task automatic test_mul();
    int ns, nm, nd, nw, nv; logic [31:0] hi, lo; logic sg; bit dn, st, lk;
    mult_lat = 3;
    run_op(OP_MUL, -32'sd3, 32'd5, 0, ns, nm, nd, nw, nv, hi, lo, sg, dn, st, lk);
    n_total++; if (!dn) $display("FAIL mul_done: no result within budget"); else n_pass++;
    n_total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mul_lo: got %h want fffffff1", lo); else n_pass++;
    n_total++; if (nw !== 0) $display("FAIL mul_no_hilo_we: got %0d want 0", nw); else n_pass++;
    n_total++; if (sg !== 1'b1) $display("FAIL mul_sign: got %b want 1", sg); else n_pass++;
  endtask

  task automatic test_flush_idle();
    op_valid = 1; op_sel = OP_MULT; src_a = 32'd2; src_b = 32'd2; flush = 1;
    @(negedge clk);
    n_total++; if (mult_start !== 1'b0) $display("FAIL flush_idle_start: got %b want 0", mult_start); else n_pass++;
    @(posedge clk); #1;
    flush = 0; op_valid = 0;
    @(negedge clk);
    n_total++; if ({stallreq, mult_busy} !== 2'b00) $display("FAIL flush_idle_stays_idle: got %b want 00", {stallreq, mult_busy}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush_done();
    int nw, nm;
    nw = 0; nm = 0; mult_lat = 1;
    op_valid = 1; op_sel = OP_MULTU; src_a = 32'd3; src_b = 32'd4; hold = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (hilo_we) nw++;
      if (mult_start) nm++;
      if (c == 2) begin
        n_total++; if ({res_valid, res_lo} !== {1'b1, 32'd12}) $display("FAIL flush_done_result: got %b/%0d want 1/12", res_valid, res_lo); else n_pass++;
      end
      if (c == 4) begin
        n_total++; if ({res_valid, stallreq} !== 2'b00) $display("FAIL flush_done_to_idle: got %b want 00", {res_valid, stallreq}); else n_pass++;
      end
      @(posedge clk); #1;
      flush = (c + 1 == 3);
      if (c + 1 == 4) begin op_valid = 0; hold = 0; end
    end
    n_total++; if (nw !== 0) $display("FAIL flush_done_hilo_we: got %0d want 0", nw); else n_pass++;
    n_total++; if (nm !== 1) $display("FAIL flush_done_no_restart: got %0d want 1", nm); else n_pass++;
  endtask

  task automatic test_flush_run();
    int first_ms, nw; bit overlap, early_valid, fin, dn; logic [31:0] lo; logic st3;
    first_ms = -1; nw = 0; overlap = 0; early_valid = 0; dn = 0; lo = '0; st3 = 0;
    div_lat = 6; mult_lat = 2;
    op_valid = 1; op_sel = OP_DIV; src_a = -32'sd20; src_b = 32'd3;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mult_start && first_ms < 0) first_ms = c;
      if (mult_start && div_busy) overlap = 1;
      if (hilo_we) nw++;
      if (res_valid && first_ms < 0) early_valid = 1;
      if (c == 3) st3 = stallreq;
      fin = res_valid && !hold;
      if (fin) lo = res_lo;
      @(posedge clk); #1;
      if (fin) begin dn = 1; break; end
      flush = (c + 1 == 2);
      if (c + 1 == 3) begin op_sel = OP_MUL; src_a = 32'd7; src_b = 32'd6; end
    end
    op_valid = 0; flush = 0;
    n_total++; if (first_ms !== 8) $display("FAIL flush_run_next_start: got cycle %0d want 8", first_ms); else n_pass++;
    n_total++; if (overlap) $display("FAIL flush_run_overlap: mult started while div busy"); else n_pass++;
    n_total++; if (early_valid) $display("FAIL flush_run_discard: res_valid before next op"); else n_pass++;
    n_total++; if (st3 !== 1'b1) $display("FAIL flush_run_abort_stall: got %b want 1", st3); else n_pass++;
    n_total++; if (nw !== 0) $display("FAIL flush_run_hilo_we: got %0d want 0", nw); else n_pass++;
    n_total++; if (!dn || lo !== 32'd42) $display("FAIL flush_run_next_result: got done %b lo %0d want 1/42", dn, lo); else n_pass++;
  endtask

  task automatic test_timeout();
    int ns, nm, nd, nw, nv; logic [31:0] hi, lo; logic sg; bit dn, st, lk;
    int n_run_stall;
    n_run_stall = 0; div_lat = 0;
    op_valid = 1; op_sel = OP_DIV; src_a = 32'd9; src_b = 32'd2;
    // Start at c=0, eight RUN cycles c=1..8, ABORT from c=9.
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 8 && stallreq) n_run_stall++;
      if (c == 8) begin
        n_total++; if (md_err !== 1'b0) $display("FAIL timeout_err_early: got %b want 0", md_err); else n_pass++;
      end
      if (c == 9) begin
        n_total++; if (md_err !== 1'b1) $display("FAIL timeout_err_set: got %b want 1", md_err); else n_pass++;
        n_total++; if ({stallreq, res_valid} !== 2'b00) $display("FAIL timeout_abort_outputs: got %b want 00", {stallreq, res_valid}); else n_pass++;
      end
      if (c == 12) begin
        n_total++; if ({stallreq, mult_start} !== 2'b10) $display("FAIL timeout_wait_busy: got %b want 10", {stallreq, mult_start}); else n_pass++;
      end
      @(posedge clk); #1;
      if (c + 1 == 9) op_valid = 0;
      if (c + 1 == 12) begin op_valid = 1; op_sel = OP_MULTU; src_a = 32'd5; src_b = 32'd6; end
    end
    n_total++; if (n_run_stall !== 8) $display("FAIL timeout_run_stall: got %0d want 8", n_run_stall); else n_pass++;
    d_abandon = 1; mult_lat = 2;
    run_op(OP_MULTU, 32'd5, 32'd6, 0, ns, nm, nd, nw, nv, hi, lo, sg, dn, st, lk);
    n_total++; if (!dn || {hi, lo} !== {32'd0, 32'd30} || nw !== 1)
      $display("FAIL timeout_recover: got done %b hi %0d lo %0d we %0d want 1/0/30/1", dn, hi, lo, nw); else n_pass++;
    n_total++; if (md_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b want 1", md_err); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int ns, nm, nd, nw, nv; logic [31:0] hi, lo; logic sg; bit dn, st, lk;
    mult_lat = 0;
    op_valid = 1; op_sel = OP_MULT; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (stallreq !== 1'b1) $display("FAIL rst_run_stall: got %b want 1", stallreq); else n_pass++;
    #1 resetn = 0;
    #1;
    n_total++; if ({stallreq, res_valid, hilo_we, md_err, mult_start, div_start} !== 6'b0)
      $display("FAIL rst_async_outputs: got %b want 000000", {stallreq, res_valid, hilo_we, md_err, mult_start, div_start}); else n_pass++;
    n_total++; if ({res_hi, res_lo} !== 64'b0) $display("FAIL rst_async_result: got %h want 0", {res_hi, res_lo}); else n_pass++;
    op_valid = 0;
    @(posedge clk); #3;
    resetn = 1;
    mult_lat = 2;
    run_op(OP_MULT, 32'd6, 32'd7, 0, ns, nm, nd, nw, nv, hi, lo, sg, dn, st, lk);
    n_total++; if (!dn || lo !== 32'd42 || hi !== 32'd0) $display("FAIL rst_next_result: got done %b hi %0d lo %0d want 1/0/42", dn, hi, lo); else n_pass++;
    n_total++; if (ns !== 3 || nm !== 1 || nw !== 1) $display("FAIL rst_next_timing: got stall %0d start %0d we %0d want 3/1/1", ns, nm, nw); else n_pass++;
    n_total++; if (md_err !== 1'b0) $display("FAIL rst_err_cleared: got %b want 0", md_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_illegal();
    test_divu_hold();
    test_mul();
    test_flush_idle();
    test_flush_done();
    test_flush_run();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
